// File: rtl/snitch_icache_pkg.sv
// Shared configuration and state types for the instruction-cache tag path.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned SET_COUNT;
    int unsigned LINE_COUNT;
    int unsigned COUNT_ALIGN;
    int unsigned TAG_WIDTH;
  } config_t;

  localparam config_t DefaultCfg = '{
    SET_COUNT:   32'd2,
    LINE_COUNT:  32'd128,
    COUNT_ALIGN: 32'd7,
    TAG_WIDTH:   32'd37
  };

  typedef enum logic [1:0] {
    TagInit  = 2'd0,
    TagIdle  = 2'd1,
    TagFlush = 2'd2
  } tag_state_e;

endpackage

// File: rtl/snitch_icache_tag_cmp.sv
// Per-way tag compare with parity check; flags parity errors and multi-way hits.
module snitch_icache_tag_cmp
  import snitch_icache_pkg::*;
#(
  parameter int unsigned SetCount = DefaultCfg.SET_COUNT,
  parameter int unsigned TagWidth = DefaultCfg.TAG_WIDTH
) (
  input  logic [SetCount-1:0][TagWidth+1:0] rtag,
  input  logic [TagWidth-1:0]               tag,
  output logic                              hit,
  output logic [SetCount-1:0]               way,
  output logic                              err
);

  typedef struct packed {
    logic                valid;
    logic                parity;
    logic [TagWidth-1:0] tag;
  } tag_entry_t;

  logic [SetCount-1:0] match;
  logic [SetCount-1:0] perr;
  logic                one_hot;
  logic                multi;
  tag_entry_t          entry;

  // A way with a parity error never counts as a match.
  always_comb begin
    match = '0;
    perr  = '0;
    entry = '0;
    for (int w = 0; w < SetCount; w++) begin
      entry    = tag_entry_t'(rtag[w]);
      perr[w]  = entry.valid & ((^entry.tag) != entry.parity);
      match[w] = entry.valid & ~perr[w] & (entry.tag == tag);
    end
  end

  assign one_hot = (match != '0) && ((match & (match - SetCount'(1))) == '0);
  assign multi   = (match != '0) && !one_hot;
  assign hit     = one_hot;
  assign way     = one_hot ? match : '0;
  assign err     = (|perr) | multi;

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag SRAM sequencer: init/flush sweeps, refill writes, lookup reads with a
// 2-cycle response pipeline, round-robin victim choice.
module snitch_icache_tag_ctrl
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG            = DefaultCfg,
  parameter type     sram_cfg_tag_t = logic
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  sram_cfg_tag_t                               sram_cfg_tag_i,
  output sram_cfg_tag_t                               sram_cfg_tag_o,
  input  logic                                        flush_valid_i,
  output logic                                        flush_ready_o,
  input  logic                                        lookup_valid_i,
  output logic                                        lookup_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                  lookup_addr_i,
  input  logic [CFG.TAG_WIDTH-1:0]                    lookup_tag_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic                                        rsp_hit_o,
  output logic [CFG.SET_COUNT-1:0]                    rsp_way_o,
  output logic                                        rsp_err_o,
  input  logic                                        refill_valid_i,
  output logic                                        refill_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                  refill_addr_i,
  input  logic [CFG.TAG_WIDTH-1:0]                    refill_tag_i,
  output logic [CFG.SET_COUNT-1:0]                    refill_way_o,
  output logic                                        busy_o,
  output logic [CFG.SET_COUNT-1:0]                    ram_enable_o,
  output logic                                        ram_write_o,
  output logic [CFG.COUNT_ALIGN-1:0]                  ram_addr_o,
  output logic [CFG.SET_COUNT-1:0][CFG.TAG_WIDTH+1:0] ram_wtag_o,
  input  logic [CFG.SET_COUNT-1:0][CFG.TAG_WIDTH+1:0] ram_rtag_i
);

  localparam int unsigned SetCount   = CFG.SET_COUNT;
  localparam int unsigned LineCount  = CFG.LINE_COUNT;
  localparam int unsigned CountAlign = CFG.COUNT_ALIGN;
  localparam int unsigned TagWidth   = CFG.TAG_WIDTH;

  typedef struct packed {
    logic                valid;
    logic                parity;
    logic [TagWidth-1:0] tag;
  } tag_entry_t;

  tag_state_e            state_q;
  logic [CountAlign-1:0] cnt_q;
  logic [SetCount-1:0]   victim_q;
  logic                  rd_pend_q;
  logic [TagWidth-1:0]   rd_tag_q;
  logic                  rsp_valid_q;
  logic                  rsp_hit_q;
  logic [SetCount-1:0]   rsp_way_q;
  logic                  rsp_err_q;

  logic                  idle;
  logic                  stall;
  logic                  flush_hs;
  logic                  refill_hs;
  logic                  lookup_hs;
  logic                  cmp_hit;
  logic [SetCount-1:0]   cmp_way;
  logic                  cmp_err;
  tag_entry_t            refill_entry;

  assign sram_cfg_tag_o = sram_cfg_tag_i;

  // A held response with a read behind it freezes every SRAM request.
  assign idle           = (state_q == TagIdle);
  assign stall          = rd_pend_q & rsp_valid_q & ~rsp_ready_i;
  assign flush_ready_o  = idle & ~rd_pend_q;
  assign refill_ready_o = idle & ~flush_valid_i & ~stall;
  assign lookup_ready_o = idle & ~flush_valid_i & ~refill_valid_i & ~stall;
  assign flush_hs       = flush_valid_i & flush_ready_o;
  assign refill_hs      = refill_valid_i & refill_ready_o;
  assign lookup_hs      = lookup_valid_i & lookup_ready_o;

  assign busy_o       = ~idle;
  assign refill_way_o = victim_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_way_o    = rsp_way_q;
  assign rsp_err_o    = rsp_err_q;

  assign refill_entry = '{valid: 1'b1, parity: ^refill_tag_i, tag: refill_tag_i};

  // SRAM request mux: sweep write, refill write to victim, or lookup read.
  always_comb begin
    ram_enable_o = '0;
    ram_write_o  = 1'b0;
    ram_addr_o   = '0;
    ram_wtag_o   = '0;
    if (!idle) begin
      ram_enable_o = '1;
      ram_write_o  = 1'b1;
      ram_addr_o   = cnt_q;
    end else if (refill_hs) begin
      ram_enable_o = victim_q;
      ram_write_o  = 1'b1;
      ram_addr_o   = refill_addr_i;
      for (int w = 0; w < SetCount; w++) begin
        ram_wtag_o[w] = refill_entry;
      end
    end else if (lookup_hs) begin
      ram_enable_o = '1;
      ram_addr_o   = lookup_addr_i;
    end
  end

  snitch_icache_tag_cmp #(
    .SetCount (SetCount),
    .TagWidth (TagWidth)
  ) i_cmp (
    .rtag (ram_rtag_i),
    .tag  (rd_tag_q),
    .hit  (cmp_hit),
    .way  (cmp_way),
    .err  (cmp_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TagInit;
      cnt_q       <= '0;
      victim_q    <= SetCount'(1);
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        TagInit, TagFlush: begin
          if (cnt_q == CountAlign'(LineCount - 1)) begin
            state_q <= TagIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CountAlign'(1);
          end
        end
        TagIdle: begin
          if (flush_hs) begin
            state_q <= TagFlush;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= TagInit;
          cnt_q   <= '0;
        end
      endcase

      if (refill_hs) begin
        victim_q <= (victim_q << 1) | SetCount'(victim_q[SetCount-1]);
      end

      if (lookup_hs) begin
        rd_tag_q <= lookup_tag_i;
      end
      rd_pend_q <= lookup_hs | stall;

      // Response register: load when the read can advance, else drain.
      if (rd_pend_q && !stall) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= cmp_hit;
        rsp_way_q   <= cmp_way;
        rsp_err_q   <= cmp_err;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Scoreboard bench for snitch_icache_tag_ctrl with a 2-way x 128-line tag SRAM model.
module tb_snitch_icache_tag_ctrl;
  import snitch_icache_pkg::*;

  localparam config_t Cfg = '{SET_COUNT: 32'd2, LINE_COUNT: 32'd128,
                              COUNT_ALIGN: 32'd7, TAG_WIDTH: 32'd37};

  logic             clk = 1'b0;
  logic             rst_i;
  logic             sram_cfg_tag_i;
  logic             sram_cfg_tag_o;
  logic             flush_valid_i;
  logic             flush_ready_o;
  logic             lookup_valid_i;
  logic             lookup_ready_o;
  logic [6:0]       lookup_addr_i;
  logic [36:0]      lookup_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_hit_o;
  logic [1:0]       rsp_way_o;
  logic             rsp_err_o;
  logic             refill_valid_i;
  logic             refill_ready_o;
  logic [6:0]       refill_addr_i;
  logic [36:0]      refill_tag_i;
  logic [1:0]       refill_way_o;
  logic             busy_o;
  logic [1:0]       ram_enable_o;
  logic             ram_write_o;
  logic [6:0]       ram_addr_o;
  logic [1:0][38:0] ram_wtag_o;
  logic [1:0][38:0] ram_rtag_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snitch_icache_tag_ctrl #(.CFG(Cfg), .sram_cfg_tag_t(logic)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .sram_cfg_tag_i (sram_cfg_tag_i),
    .sram_cfg_tag_o (sram_cfg_tag_o),
    .flush_valid_i  (flush_valid_i),
    .flush_ready_o  (flush_ready_o),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_tag_i   (lookup_tag_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_hit_o      (rsp_hit_o),
    .rsp_way_o      (rsp_way_o),
    .rsp_err_o      (rsp_err_o),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_addr_i  (refill_addr_i),
    .refill_tag_i   (refill_tag_i),
    .refill_way_o   (refill_way_o),
    .busy_o         (busy_o),
    .ram_enable_o   (ram_enable_o),
    .ram_write_o    (ram_write_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wtag_o     (ram_wtag_o),
    .ram_rtag_i     (ram_rtag_i)
  );

  // Tag SRAM model: read data only changes on a read request; poke flips a parity bit.
  logic [38:0] mem [2][128];
  logic        poke_req = 1'b0;
  logic        poke_way = 1'b0;
  logic [6:0]  poke_line = '0;

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (ram_enable_o[w]) begin
        if (ram_write_o) mem[w][ram_addr_o] <= ram_wtag_o[w];
        else             ram_rtag_i[w] <= mem[w][ram_addr_o];
      end
    end
    if (poke_req) mem[poke_way][poke_line] <= mem[poke_way][poke_line] ^ (39'(1) << 37);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the tag contents and victim pointer.
  logic [38:0] ref_mem [2][128];
  logic [1:0]  m_victim;
  logic [3:0]  sb [$];

  function automatic logic [3:0] exp_rsp(input logic [6:0] line, input logic [36:0] tag);
    logic [1:0]  m;
    logic        e;
    logic [38:0] ent;
    m = '0;
    e = 1'b0;
    for (int w = 0; w < 2; w++) begin
      ent = ref_mem[w][line];
      if (ent[38] && (ent[37] != ^ent[36:0])) e = 1'b1;
      else if (ent[38] && ent[36:0] == tag) m[w] = 1'b1;
    end
    if (m == 2'b11) return 4'b0001;
    return {|m, m, e};
  endfunction

  // Monitor: pushes expected lookup results, pops on response handshake.
  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      m_victim <= 2'b01;
      for (int w = 0; w < 2; w++)
        for (int l = 0; l < 128; l++) ref_mem[w][l] <= '0;
    end else begin
      if (rsp_valid_o && rsp_ready_i) begin
        chk("rsp_q", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("rsp", {rsp_hit_o, rsp_way_o, rsp_err_o}, sb.pop_front());
      end
      if (refill_valid_i && refill_ready_o) begin
        chk("rf_victim", refill_way_o, m_victim);
        chk("rf_req", {ram_write_o, ram_enable_o, ram_addr_o}, {1'b1, m_victim, refill_addr_i});
        chk("rf_data", ram_wtag_o[m_victim[1]], {1'b1, ^refill_tag_i, refill_tag_i});
        ref_mem[m_victim[1]][refill_addr_i] <= {1'b1, ^refill_tag_i, refill_tag_i};
        m_victim <= {m_victim[0], m_victim[1]};
      end
      if (lookup_valid_i && lookup_ready_o) begin
        chk("lk_req", {ram_write_o, ram_enable_o, ram_addr_o}, {1'b0, 2'b11, lookup_addr_i});
        sb.push_back(exp_rsp(lookup_addr_i, lookup_tag_i));
      end
      if (flush_valid_i && flush_ready_o) begin
        for (int w = 0; w < 2; w++)
          for (int l = 0; l < 128; l++) ref_mem[w][l] <= '0;
      end
      if (poke_req) ref_mem[poke_way][poke_line] <= ref_mem[poke_way][poke_line] ^ (39'(1) << 37);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_refill(input logic [6:0] line, input logic [36:0] tag, input logic [1:0] exp_way);
    int k = 0;
    refill_valid_i = 1'b1;
    refill_addr_i  = line;
    refill_tag_i   = tag;
    @(negedge clk);
    while (!refill_ready_o && k < 200) begin @(negedge clk); k++; end
    chk("rf_rdy", refill_ready_o, 1'b1);
    chk("rf_way", refill_way_o, exp_way);
    step();
    refill_valid_i = 1'b0;
  endtask

  task automatic do_lookup(input logic [6:0] line, input logic [36:0] tag);
    int k = 0;
    lookup_valid_i = 1'b1;
    lookup_addr_i  = line;
    lookup_tag_i   = tag;
    @(negedge clk);
    while (!lookup_ready_o && k < 200) begin @(negedge clk); k++; end
    chk("lk_rdy", lookup_ready_o, 1'b1);
    step();
    lookup_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    int k = 0;
    flush_valid_i = 1'b1;
    @(negedge clk);
    while (!flush_ready_o && k < 200) begin @(negedge clk); k++; end
    chk("fl_rdy", flush_ready_o, 1'b1);
    step();
    flush_valid_i = 1'b0;
  endtask

  // Expects a full sweep starting at line 0 in the current cycle.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      chk(tag, {busy_o, ram_write_o, ram_enable_o, ram_addr_o, ram_wtag_o == '0},
          {1'b1, 1'b1, 2'b11, 7'(i), 1'b1});
    end
    @(negedge clk);
    chk({tag, "_end"}, busy_o, 1'b0);
    chk({tag, "_rdy"}, {lookup_ready_o, refill_ready_o, flush_ready_o}, 3'b111);
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    sram_cfg_tag_i = 1'b1;
    flush_valid_i = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_addr_i = '0;
    lookup_tag_i = '0;
    rsp_ready_i = 1'b1;
    refill_valid_i = 1'b0;
    refill_addr_i = '0;
    refill_tag_i = '0;

    // Reset state and init sweep
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {lookup_ready_o, refill_ready_o, flush_ready_o, rsp_valid_o, busy_o,
                  ram_write_o, ram_enable_o, ram_addr_o, refill_way_o},
        {5'b00001, 1'b1, 2'b11, 7'd0, 2'b01});
    chk("sram_cfg", sram_cfg_tag_o, 1'b1);
    rst_i = 1'b0;
    check_sweep("sweep_init");

    // Refill then lookup with latency check
    do_refill(7'd5, 37'h1234, 2'b01);
    do_lookup(7'd5, 37'h1234);
    @(negedge clk);
    chk("lat1", rsp_valid_o, 1'b0);
    @(negedge clk);
    chk("lat2", {rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_err_o}, 5'b11010);
    step();

    // Victim rotation and wrap
    do_refill(7'd5, 37'h99, 2'b10);
    do_lookup(7'd5, 37'h99);
    do_refill(7'd5, 37'h555, 2'b01);
    do_lookup(7'd5, 37'h1234);
    do_lookup(7'd5, 37'h555);
    idle(4);

    // Back-to-back lookups against a stalled response
    rsp_ready_i = 1'b0;
    fork
      begin
        do_lookup(7'd5, 37'h99);
        do_lookup(7'd5, 37'h555);
        do_lookup(7'd6, 37'h99);
        do_lookup(7'd5, 37'h1234);
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!rsp_valid_o && k < 50) begin @(negedge clk); k++; end
        for (int i = 0; i < 3; i++) begin
          chk("stall_ram", ram_enable_o, 2'b00);
          chk("stall_rdy", lookup_ready_o, 1'b0);
          chk("stall_hold", {rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_err_o}, 5'b11100);
          if (i < 2) @(negedge clk);
        end
        step();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("drain", rsp_valid_o, 1'b1);
        end
      end
    join
    idle(4);

    // Parity error and multi-way hit
    poke_way = 1'b1;
    poke_line = 7'd5;
    poke_req = 1'b1;
    step();
    poke_req = 1'b0;
    do_lookup(7'd5, 37'h99);
    do_refill(7'd7, 37'hAB, 2'b10);
    do_refill(7'd7, 37'hAB, 2'b01);
    do_lookup(7'd7, 37'hAB);
    idle(4);

    // Held response survives a flush issued with the read in flight
    rsp_ready_i = 1'b0;
    do_lookup(7'd5, 37'h555);
    do_flush();
    check_sweep("sweep_flush");
    @(negedge clk);
    chk("held", {rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_err_o}, 5'b11011);
    step();
    rsp_ready_i = 1'b1;
    do_lookup(7'd5, 37'h555);
    do_lookup(7'd7, 37'hAB);
    do_lookup(7'd5, 37'h99);
    idle(4);

    // Refill beats a same-cycle lookup
    refill_valid_i = 1'b1;
    refill_addr_i = 7'd9;
    refill_tag_i = 37'h77;
    lookup_valid_i = 1'b1;
    lookup_addr_i = 7'd9;
    lookup_tag_i = 37'h77;
    @(negedge clk);
    chk("arb_rf", {refill_ready_o, lookup_ready_o, refill_way_o}, 4'b1010);
    step();
    refill_valid_i = 1'b0;
    @(negedge clk);
    chk("arb_lk", lookup_ready_o, 1'b1);
    step();
    lookup_valid_i = 1'b0;
    idle(4);

    // Reset at flush line 60 with a held response
    rsp_ready_i = 1'b0;
    do_lookup(7'd9, 37'h77);
    do_flush();
    idle(60);
    rst_i = 1'b1;
    @(negedge clk);
    chk("sweep60", {busy_o, ram_addr_o}, {1'b1, 7'd60});
    step();
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    chk("rst_rsp", {rsp_valid_o, busy_o, ram_addr_o}, {1'b0, 1'b1, 7'd0});
    check_sweep("sweep_rst");
    do_lookup(7'd9, 37'h77);
    do_refill(7'd9, 37'h77, 2'b01);
    idle(4);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
